// File: rtl/alu_seq.sv
// alu_seq -- registered, handshaked ALU with an iterative multiplier.
//
// Holds one operation in flight. Single-cycle ops (AND/OR/XOR/ADD/SUB/LOAD/
// NOP) complete on the accept edge. MUL runs WIDTH shift-add steps and then
// completes. Every completion also writes the low result into the
// accumulator, which acc_en can select as operand A.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   operation handshake (in1, in2, select, acc_en)
//   out_valid/out_ready result handshake (result, hi, carry, borrow, zero)
//   busy                multiply in progress
module alu_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       select,
  input  logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             carry,
  output logic             borrow,
  output logic             zero,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_e;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_LOAD = 3'b110;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic                 carry_q, carry_d;
  logic                 borrow_q, borrow_d;
  logic                 zero_q, zero_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  // Multiplicand shifts left, multiplier shifts right; each step adds the
  // shifted multiplicand when the current multiplier LSB is set.
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;

  logic [WIDTH-1:0]     op_a;
  logic [WIDTH:0]       sum, diff;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c, alu_b;
  logic [2*WIDTH-1:0]   prod_nxt;
  logic                 accept;

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_HOLD && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_HOLD);
  assign busy      = (state_q == S_MUL);
  assign result    = result_q;
  assign hi        = hi_q;
  assign carry     = carry_q;
  assign borrow    = borrow_q;
  assign zero      = zero_q;

  // Single-cycle datapath
  always_comb begin
    op_a    = acc_en ? acc_q : in1;
    sum     = {1'b0, op_a} + {1'b0, in2};
    diff    = {1'b0, op_a} - {1'b0, in2};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_b   = 1'b0;
    case (select)
      OP_AND:  alu_res = op_a & in2;
      OP_OR:   alu_res = op_a | in2;
      OP_XOR:  alu_res = op_a ^ in2;
      OP_ADD:  {alu_c, alu_res} = sum;
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_b   = diff[WIDTH];      // wraps negative exactly when A < B
      end
      OP_LOAD: alu_res = in2;
      default: alu_res = '0;        // NOP; MUL takes the iterative path
    endcase
  end

  assign prod_nxt = prod_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    hi_d     = hi_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;

    case (state_q)
      S_IDLE, S_HOLD: begin
        if (state_q == S_HOLD && out_ready) state_d = S_IDLE;
        if (accept) begin
          if (select == OP_MUL) begin
            mcand_d  = {{WIDTH{1'b0}}, op_a};
            mplier_d = in2;
            prod_d   = '0;
            cnt_d    = CNT_W'(WIDTH - 1);
            state_d  = S_MUL;
          end else begin
            result_d = alu_res;
            hi_d     = '0;
            carry_d  = alu_c;
            borrow_d = alu_b;
            zero_d   = (alu_res == '0);
            acc_d    = alu_res;
            state_d  = S_HOLD;
          end
        end
      end
      S_MUL: begin
        prod_d   = prod_nxt;
        mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          {hi_d, result_d} = prod_nxt;
          carry_d  = 1'b0;
          borrow_d = 1'b0;
          zero_d   = (prod_nxt == '0);
          acc_d    = prod_nxt[WIDTH-1:0];
          cnt_d    = '0;
          state_d  = S_HOLD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      hi_q     <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

endmodule
